hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of each event counter.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of consecutive MEM_busy cycles allowed before mem_timeout is raised.
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
  - clk  in  1  single clock; all state updates on rising edge.
  - rstn  in  1  reset; asynchronous, active-low.
  - IF_ID_rs1  in  5  source register 1 of the instruction in ID.
  - IF_ID_rs2  in  5  source register 2 of the instruction in ID.
  - IF_ID_use_rs1  in  1  ID instruction reads rs1.
  - IF_ID_use_rs2  in  1  ID instruction reads rs2.
  - ID_EX_rd  in  5  destination register of the instruction in EX.
  - ID_EX_MemRead  in  1  EX instruction is a load.
  - EX_redirect  in  1  branch taken or jump resolved in EX.
  - MEM_busy  in  1  data memory not ready; the pipeline freezes.
  - CTRL_SELECT  out  1  1 passes ID control signals into ID/EX; 0 inserts a bubble.
  - PC_Write  out  1  PC update enable.
  - IF_ID_Write  out  1  IF/ID register enable.
  - IF_ID_Flush  out  1  clears IF/ID to a NOP.
  - ID_EX_Write  out  1  ID/EX register enable.
  - stall_cnt  out  CNT_W  count of load-use bubbles.
  - flush_cnt  out  CNT_W  count of redirect flushes.
  - wait_cnt  out  CNT_W  count of MEM_busy cycles.
  - mem_timeout  out  1  sticky flag: memory wait exceeded TIMEOUT.

Function
REQ-004 SHALL compute the control outputs combinationally from the current inputs, with zero-cycle latency.
REQ-005 SHALL define load_use as: ID_EX_MemRead=1, ID_EX_rd≠0, and either (IF_ID_use_rs1=1 and rs1=rd) or (IF_ID_use_rs2=1 and rs2=rd).
REQ-006 SHALL apply this priority, highest first: MEM_busy, then EX_redirect, then load_use, then normal operation.
REQ-007 SHALL, when MEM_busy=1, drive PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, IF_ID_Flush=0 and CTRL_SELECT=1, so that all stages hold and no bubble is inserted.
REQ-008 SHALL, when EX_redirect=1 and MEM_busy=0, drive IF_ID_Flush=1 and CTRL_SELECT=0, with PC_Write=1, IF_ID_Write=1 and ID_EX_Write=1.
REQ-009 SHALL, when load_use=1 and no higher-priority event is present, drive CTRL_SELECT=0, PC_Write=0, IF_ID_Write=0, ID_EX_Write=1 and IF_ID_Flush=0.
REQ-010 SHALL, in normal operation, drive CTRL_SELECT=1, all write enables=1 and IF_ID_Flush=0.
REQ-011 SHALL implement an FSM with two states: RUN and MEMWAIT.
  - RUN goes to MEMWAIT on MEM_busy=1.
  - MEMWAIT stays in MEMWAIT while MEM_busy=1.
  - MEMWAIT returns to RUN on MEM_busy=0.
REQ-012 SHALL hold a wait-length counter of at least 9 bits that is cleared on entry to MEMWAIT and increments each MEMWAIT cycle with MEM_busy=1.
REQ-013 SHALL set mem_timeout on the edge at which the wait-length counter reaches TIMEOUT; the flag stays set until reset.
REQ-014 SHALL increment stall_cnt on each clock edge where REQ-009 applies, flush_cnt on each edge where REQ-008 applies, and wait_cnt on each edge where MEM_busy=1.
REQ-015 SHALL saturate every counter at all-ones with no wrap-around.
REQ-016 SHALL ensure that a load_use coinciding with EX_redirect produces a flush only: stall_cnt unchanged, flush_cnt +1.
REQ-017 SHALL ensure that a redirect or load_use present during MEM_busy neither acts nor counts until MEM_busy falls; the frozen EX stage re-presents it.

Reset
REQ-018 SHALL, while rstn=0, force state=RUN, all counters=0, mem_timeout=0, CTRL_SELECT=0, PC_Write=0, IF_ID_Write=0, ID_EX_Write=0 and IF_ID_Flush=1.
REQ-019 SHALL abandon any in-progress MEMWAIT or wait-length count immediately on assertion of rstn=0, independent of clk.
REQ-020 SHALL resume the REQ-004 to REQ-010 behaviour in the first cycle after rstn rises.

Structure
REQ-021 SHALL take the FSM state encoding (RUN, MEMWAIT) and the default CNT_W from the shared pipeline package, alongside the NPCOp and ALUOp encodings.
REQ-022 SHALL instantiate a sub-module sat_counter (parameter width; ports clk, rstn, inc, count) three times, once per event counter.

Verification
REQ-023 SHALL cover: load at ID_EX_rd=5 with ID reading rs1=5 -> one cycle of CTRL_SELECT=0, PC_Write=0, IF_ID_Write=0; stall_cnt=1.
REQ-024 SHALL cover: ID_EX_rd=0 with MemRead=1 and rs1=0 -> no stall; CTRL_SELECT=1.
REQ-025 SHALL cover: EX_redirect=1 together with load_use -> IF_ID_Flush=1, CTRL_SELECT=0, PC_Write=1; flush_cnt=1, stall_cnt=0.
REQ-026 SHALL cover: MEM_busy=1 for 3 cycles with EX_redirect=1 -> all write enables=0 and no flush for 3 cycles, then a flush on the 4th cycle; wait_cnt=3, flush_cnt=1.
REQ-027 SHALL cover: TIMEOUT=4 and MEM_busy held for 6 cycles -> mem_timeout rises after the 4th busy cycle and stays 1 after MEM_busy drops.
REQ-028 SHALL cover: CNT_W=4 with 20 load-use events -> stall_cnt=15; then rstn pulsed low mid-MEMWAIT -> all counters=0, state RUN and IF_ID_Flush=1 during reset.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: next-PC and ALU encodings, hazard FSM
// states, the default event-counter width and the hazard control bundle.
package hazard_ctrl_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MEMWAIT = 1'b1;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JAL    = 2'd2,
        NPC_JALR   = 2'd3
    } npc_op_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic ctrl_select;
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic if_id_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t HZ_FREEZE = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t HZ_FLUSH  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam hz_ctrl_t HZ_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t HZ_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: freeze on memory wait, flush on redirect,
// bubble on load-use, plus event counters and a memory-wait watchdog.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_redirect,
    input  logic             MEM_busy,
    output logic             CTRL_SELECT,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             mem_timeout
);

    localparam int WL_W =
        ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;
    localparam logic [WL_W-1:0] WL_MAX = WL_W'(TIMEOUT);

    logic            rs1_hit;
    logic            rs2_hit;
    logic            load_use;
    hz_ctrl_t        ctl;
    logic            inc_stall;
    logic            inc_flush;
    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [WL_W-1:0] wlen_q;
    logic [WL_W-1:0] wlen_d;
    logic            timeout_q;
    logic            timeout_d;

    assign rs1_hit  = IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd);
    assign rs2_hit  = IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd);
    assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0)
                    && (rs1_hit || rs2_hit);

    // Qualifiers are mutually exclusive so the priority is explicit.
    always_comb begin
        ctl       = HZ_RUN;
        inc_stall = 1'b0;
        inc_flush = 1'b0;
        unique case (1'b1)
            !rstn: ctl = HZ_RESET;
            rstn && MEM_busy: ctl = HZ_FREEZE;
            rstn && !MEM_busy && EX_redirect: begin
                ctl       = HZ_FLUSH;
                inc_flush = 1'b1;
            end
            rstn && !MEM_busy && !EX_redirect && load_use: begin
                ctl       = HZ_STALL;
                inc_stall = 1'b1;
            end
            default: ;
        endcase
    end

    assign CTRL_SELECT = ctl.ctrl_select;
    assign PC_Write    = ctl.pc_write;
    assign IF_ID_Write = ctl.if_id_write;
    assign ID_EX_Write = ctl.id_ex_write;
    assign IF_ID_Flush = ctl.if_id_flush;

    // The entering busy cycle counts as the first cycle of the wait.
    always_comb begin
        state_d   = state_q;
        wlen_d    = wlen_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_RUN: begin
                if (MEM_busy) begin
                    state_d = ST_MEMWAIT;
                    wlen_d  = WL_W'(1);
                end
            end
            ST_MEMWAIT: begin
                if (!MEM_busy) begin
                    state_d = ST_RUN;
                end else if (wlen_q < WL_MAX) begin
                    wlen_d = wlen_q + WL_W'(1);
                end
            end
        endcase
        if ((state_d == ST_MEMWAIT) && (wlen_d >= WL_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_RUN;
            wlen_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wlen_q    <= wlen_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (inc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (inc_flush),
        .count (flush_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (MEM_busy),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two parameterisations share one stimulus stream
// and are checked every cycle against a behavioural model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mrd, redir, busy;

    logic        a_cs, a_pc, a_ifid, a_flush, a_idex, a_to;
    logic [15:0] a_st, a_fl, a_wt;
    logic        b_cs, b_pc, b_ifid, b_flush, b_idex, b_to;
    logic [3:0]  b_st, b_fl, b_wt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16), .TIMEOUT(255)) dut_a (
        .clk(clk), .rstn(rstn),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
        .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
        .ID_EX_rd(rd), .ID_EX_MemRead(mrd),
        .EX_redirect(redir), .MEM_busy(busy),
        .CTRL_SELECT(a_cs), .PC_Write(a_pc), .IF_ID_Write(a_ifid),
        .IF_ID_Flush(a_flush), .ID_EX_Write(a_idex),
        .stall_cnt(a_st), .flush_cnt(a_fl), .wait_cnt(a_wt),
        .mem_timeout(a_to)
    );

    hazard_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut_b (
        .clk(clk), .rstn(rstn),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
        .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
        .ID_EX_rd(rd), .ID_EX_MemRead(mrd),
        .EX_redirect(redir), .MEM_busy(busy),
        .CTRL_SELECT(b_cs), .PC_Write(b_pc), .IF_ID_Write(b_ifid),
        .IF_ID_Flush(b_flush), .ID_EX_Write(b_idex),
        .stall_cnt(b_st), .flush_cnt(b_fl), .wait_cnt(b_wt),
        .mem_timeout(b_to)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: event tallies and current busy-run length
    int cmax[2] = '{65535, 15};
    int tmo[2]  = '{255, 4};
    int m_st[2], m_fl[2], m_wt[2], m_run[2];
    bit m_to[2];

    function automatic bit lu_f();
        return mrd && (rd != 5'd0) &&
               ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    endfunction

    // {CTRL_SELECT, PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush}
    function automatic logic [4:0] exp_ctl();
        if (!rstn)  return 5'b00001;
        if (busy)   return 5'b10000;
        if (redir)  return 5'b01111;
        if (lu_f()) return 5'b00010;
        return 5'b11110;
    endfunction

    always @(posedge clk or negedge rstn) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                m_st[k]  <= 0;
                m_fl[k]  <= 0;
                m_wt[k]  <= 0;
                m_run[k] <= 0;
                m_to[k]  <= 1'b0;
            end else if (busy) begin
                if (m_wt[k] < cmax[k]) m_wt[k] <= m_wt[k] + 1;
                if (m_run[k] < 100000) m_run[k] <= m_run[k] + 1;
                if (m_run[k] + 1 >= tmo[k]) m_to[k] <= 1'b1;
            end else begin
                m_run[k] <= 0;
                if (redir) begin
                    if (m_fl[k] < cmax[k]) m_fl[k] <= m_fl[k] + 1;
                end else if (lu_f()) begin
                    if (m_st[k] < cmax[k]) m_st[k] <= m_st[k] + 1;
                end
            end
        end
    end

    bit         cmp_en = 1'b0;
    logic [4:0] e_ctl;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_ctl = exp_ctl();
            chk("a_ctl", {a_cs, a_pc, a_ifid, a_idex, a_flush}, e_ctl);
            chk("b_ctl", {b_cs, b_pc, b_ifid, b_idex, b_flush}, e_ctl);
            chk("a_stall", a_st, m_st[0]);
            chk("a_flushc", a_fl, m_fl[0]);
            chk("a_wait", a_wt, m_wt[0]);
            chk("a_tmo", a_to, m_to[0]);
            chk("b_stall", b_st, m_st[1]);
            chk("b_flushc", b_fl, m_fl[1]);
            chk("b_wait", b_wt, m_wt[1]);
            chk("b_tmo", b_to, m_to[1]);
        end
    end

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] d, input logic u1,
                          input logic u2, input logic m,
                          input logic rdr, input logic b);
        rs1 = r1; rs2 = r2; rd = d;
        use1 = u1; use2 = u2; mrd = m;
        redir = rdr; busy = b;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        cmp_en = 1'b1;
        mid();
        chk("rst_flush", a_flush, 1);
        chk("rst_cs", a_cs, 0);
        chk("rst_pc", a_pc, 0);
        chk("rst_stall", a_st, 0);
        tick();
        rstn = 1'b1;

        // load at rd=5, ID reads rs1=5
        set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        mid();
        chk("lu_cs", a_cs, 0);
        chk("lu_pc", a_pc, 0);
        chk("lu_ifid", a_ifid, 0);
        chk("lu_idex", a_idex, 1);
        tick();
        idle();
        chk("lu_cnt", a_st, 1);
        mid();
        chk("lu_after_cs", a_cs, 1);

        // rd=0 never stalls
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        mid();
        chk("x0_cs", a_cs, 1);
        chk("x0_pc", a_pc, 1);
        tick();
        chk("x0_cnt", a_st, 1);

        // redirect with load-use: flush only
        do_reset();
        set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        mid();
        chk("rl_flush", a_flush, 1);
        chk("rl_cs", a_cs, 0);
        chk("rl_pc", a_pc, 1);
        tick();
        idle();
        chk("rl_flushc", a_fl, 1);
        chk("rl_stall", a_st, 0);

        // redirect held under a 3-cycle memory wait
        do_reset();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("mb_pc", a_pc, 0);
            chk("mb_ifid", a_ifid, 0);
            chk("mb_idex", a_idex, 0);
            chk("mb_flush", a_flush, 0);
            tick();
        end
        busy = 1'b0;
        mid();
        chk("mb_flush4", a_flush, 1);
        tick();
        idle();
        chk("mb_wait", a_wt, 3);
        chk("mb_flushc", a_fl, 1);

        // watchdog with TIMEOUT=4
        do_reset();
        busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("to_b", b_to, (i >= 4) ? 1 : 0);
        end
        busy = 1'b0;
        tick();
        tick();
        chk("to_sticky", b_to, 1);
        chk("to_a", a_to, 0);

        // 4-bit counter saturation, then reset mid-wait
        do_reset();
        set_in(5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) tick();
        chk("sat_b", b_st, 15);
        chk("sat_a", a_st, 20);
        idle();
        busy = 1'b1;
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        chk("mw_rst_flush", b_flush, 1);
        chk("mw_rst_cs", b_cs, 0);
        chk("mw_rst_stall", b_st, 0);
        chk("mw_rst_wait", b_wt, 0);
        tick();
        rstn = 1'b1;
        tick();
        tick();
        tick();
        chk("mw_fresh_to", b_to, 0);
        tick();
        chk("mw_fresh_to4", b_to, 1);
        busy = 1'b0;
        tick();

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!rstn) rstn = 1'b1;
            else if ($urandom_range(0, 199) == 0) rstn = 1'b0;
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 3));
            use1  = 1'($urandom_range(0, 1));
            use2  = 1'($urandom_range(0, 1));
            mrd   = ($urandom_range(0, 9) < 4);
            redir = ($urandom_range(0, 9) < 2);
            if (busy) busy = ($urandom_range(0, 9) < 8);
            else      busy = ($urandom_range(0, 9) < 2);
        end
        rstn = 1'b1;
        idle();
        tick();
        mid();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
